constmap_arb: RTL and testbench



---
 rtl/constmap_pkg.sv | 22 ++
 rtl/rr_pick.sv | 19 +
 rtl/constmap_arb.sv | 91 +++++++++
 tb/tb_constmap_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/constmap_pkg.sv
// Shared types and constants for the note-to-phase-increment constant ROM scheduler.
package constmap_pkg;
  localparam int NOTE_W  = 9;
  localparam int ROM_AW  = 8;
  localparam int CONST_W = 24;
  localparam logic [ROM_AW-1:0] SAT_ADDR = 8'hFF;

  typedef enum logic [1:0] {IDLE, WAIT, CAP} state_t;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic              err;
  } lookup_t;

  // Notes with the top bit set are out of range and read the last ROM word.
  function automatic lookup_t note2lookup(input logic [NOTE_W-1:0] n);
    lookup_t lk;
    lk.err  = n[NOTE_W-1];
    lk.addr = n[NOTE_W-1] ? SAT_ADDR : n[ROM_AW-1:0];
    return lk;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt,
  output logic            any
);
  // Scan from farthest to nearest so the closest set bit wins.
  always_comb begin
    gnt = '0;
    any = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) gnt = IDW'((int'(ptr) + k) % NREQ);
    end
  end
endmodule

// File: rtl/constmap_arb.sv
// Round-robin scheduler sharing one synchronous constant ROM among NREQ requesters.
module constmap_arb
  import constmap_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*NOTE_W-1:0]   note,
  output logic [NREQ-1:0]          ack,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [CONST_W-1:0]       rom_q,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [CONST_W-1:0]       rsp_const,
  output logic                     rsp_err
);
  localparam int IDW   = $clog2(NREQ);
  localparam int CNT_W = 3;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0]   ptr, id, gnt;
  logic             any, err_l;
  logic [NOTE_W-1:0] gnote;
  lookup_t          lk;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .any (any)
  );

  assign gnote = note[int'(gnt)*NOTE_W +: NOTE_W];
  assign lk    = note2lookup(gnote);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any) state_n = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_n = CAP;
      CAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ptr only advances once the answer is captured, so a reset mid-lookup leaves it at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      err_l     <= 1'b0;
      ack       <= '0;
      rom_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_const <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ack       <= '0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: if (any) begin
          id       <= gnt;
          ack[gnt] <= 1'b1;
          rom_addr <= lk.addr;
          err_l    <= lk.err;
          cnt      <= CNT_W'(ROM_LAT);
        end
        WAIT: cnt <= cnt - CNT_W'(1);
        CAP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id;
          rsp_const <= rom_q;
          rsp_err   <= err_l;
          ptr       <= (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_constmap_arb.sv
// Scoreboard bench: two scheduler instances (ROM latency 1 and 3) against a cycle-count reference model.
module tb_constmap_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    int             due;
    logic [N-1:0]   oh;
    logic [7:0]     addr;
  } gexp_t;

  typedef struct {
    int          due;
    int          id;
    logic [23:0] k;
    logic        err;
  } rexp_t;

  function automatic logic [23:0] rom_f(input logic [7:0] a);
    return {16'h0, a} * 24'd3;
  endfunction

  task automatic chk(input int lat, input string nm, input logic [31:0] act, input logic [31:0] want);
    ntot++;
    if (act === want) npass++;
    else $display("FAIL L%0d %s: got %0h expected %0h", lat, nm, act, want);
  endtask

  for (genvar c = 0; c < 2; c++) begin : cfg
    localparam int LAT = (c == 0) ? 1 : 3;

    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*9-1:0]    note;
    logic [N-1:0]      ack;
    logic [7:0]        rom_addr;
    logic [23:0]       rom_q;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [23:0]       rsp_const;
    logic              rsp_err;
    logic              fin;
    logic [23:0]       rom_pipe [LAT];

    int    cyc;
    int    free_at;
    int    ptr_m;
    gexp_t gq[$];
    rexp_t rq[$];
    int    glog[$];

    constmap_arb #(.NREQ(N), .ROM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .req       (req),
      .note      (note),
      .ack       (ack),
      .rom_addr  (rom_addr),
      .rom_q     (rom_q),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_const (rsp_const),
      .rsp_err   (rsp_err)
    );

    // External ROM with LAT cycles from address edge to valid data.
    always @(posedge clk) begin
      rom_pipe[0] <= rom_f(rom_addr);
      for (int j = 1; j < LAT; j++) rom_pipe[j] <= rom_pipe[j-1];
    end
    assign rom_q = rom_pipe[LAT-1];

    // Reference model: one lookup occupies LAT+2 sampling edges; answers come LAT+1 edges after the grant.
    initial begin : model
      int g;
      logic [8:0] nt;
      gexp_t ge;
      rexp_t re;
      cyc = 0; free_at = 0; ptr_m = 0;
      forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
          gq.delete(); rq.delete();
          ptr_m = 0; free_at = 0;
        end else if (cyc >= free_at && req != '0) begin
          g = 0;
          for (int k = N - 1; k >= 0; k--) if (req[(ptr_m + k) % N]) g = (ptr_m + k) % N;
          nt      = note[g*9 +: 9];
          ge.due  = cyc;
          ge.oh   = 4'b0001 << g;
          ge.addr = nt[8] ? 8'd255 : nt[7:0];
          re.due  = cyc + LAT + 1;
          re.id   = g;
          re.k    = rom_f(ge.addr);
          re.err  = nt[8];
          gq.push_back(ge);
          rq.push_back(re);
          ptr_m   = (g + 1) % N;
          free_at = cyc + LAT + 2;
        end
      end
    end

    initial begin : mon
      gexp_t ge;
      rexp_t re;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (gq.size() > 0 && gq[0].due == cyc) begin
            ge = gq.pop_front();
            chk(LAT, "ack", 32'(ack), 32'(ge.oh));
            chk(LAT, "rom_addr", 32'(rom_addr), 32'(ge.addr));
            glog.push_back(int'(ack));
          end else chk(LAT, "ack_idle", 32'(ack), 0);
          if (rq.size() > 0 && rq[0].due == cyc) begin
            re = rq.pop_front();
            chk(LAT, "rsp_valid", 32'(rsp_valid), 1);
            chk(LAT, "rsp_id", 32'(rsp_id), 32'(re.id));
            chk(LAT, "rsp_const", 32'(rsp_const), 32'(re.k));
            chk(LAT, "rsp_err", 32'(rsp_err), 32'(re.err));
          end else chk(LAT, "rsp_idle", 32'(rsp_valid), 0);
        end
      end
    end

    task automatic step();
      @(negedge clk);
      #1;
    endtask

    task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string nm);
      chk(LAT, {nm, "_ack"}, 32'(ack), 0);
      chk(LAT, {nm, "_rom_addr"}, 32'(rom_addr), 0);
      chk(LAT, {nm, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk(LAT, {nm, "_rsp_id"}, 32'(rsp_id), 0);
      chk(LAT, {nm, "_rsp_const"}, 32'(rsp_const), 0);
      chk(LAT, {nm, "_rsp_err"}, 32'(rsp_err), 0);
    endtask

    // Full handshake: hold until own ack is seen, then drop.
    task automatic do_req(input int i, input logic [8:0] n);
      bit seen;
      seen = 1'b0;
      note[i*9 +: 9] = n;
      req[i] = 1'b1;
      for (int t = 0; t < 40 && !seen; t++) begin
        step();
        seen = ack[i];
      end
      req[i] = 1'b0;
      chk(LAT, "ack_seen", 32'(seen), 1);
    endtask

    initial begin : drv
      fin = 1'b0; rst_n = 1'b0; req = '0; note = '0;
      step();
      step();
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // single in-range request
      do_req(2, 9'd57);
      repeat (8) step();

      // all requesters held: rotation must start at 0 after reset
      do_reset();
      glog.delete();
      for (int t = 0; t < 8*LAT + 16; t++) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && ack[i]) req[i] = 1'b0;
          else if (!req[i]) begin
            note[i*9 +: 9] = 9'($urandom_range(0, 255));
            req[i] = 1'b1;
          end
        end
        step();
      end
      req = '0;
      repeat (10) step();
      for (int j = 0; j < 5; j++) chk(LAT, "rr_order", 32'(glog[j]), 32'(1 << (j % 4)));

      // out-of-range note saturates
      do_req(1, 9'd300);
      repeat (8) step();

      // reset during WAIT discards the lookup
      do_req(0, 9'd5);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      step();
      step();
      rst_n = 1'b1;
      repeat (8) step();
      do_req(3, 9'd77);
      chk(LAT, "req3_after_reset", 32'(ack), 32'(4'b1000));
      repeat (8) step();

      // one-cycle pulse while busy is withdrawn
      do_req(0, 9'd10);
      note[9 +: 9] = 9'd20;
      req[1] = 1'b1;
      step();
      req[1] = 1'b0;
      repeat (8) step();

      // random traffic with occasional withdrawal
      for (int t = 0; t < 300; t++) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && ack[i]) req[i] = 1'b0;
          else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
          else if (!req[i] && $urandom_range(0, 3) == 0) begin
            note[i*9 +: 9] = 9'($urandom_range(0, 511));
            req[i] = 1'b1;
          end
        end
        step();
      end
      req = '0;
      repeat (12) step();
      chk(LAT, "grants_drained", 32'(gq.size()), 0);
      chk(LAT, "rsps_drained", 32'(rq.size()), 0);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (cfg[0].fin && cfg[1].fin);
      #200000;
    join_any
    if (!(cfg[0].fin && cfg[1].fin)) begin
      ntot++;
      $display("FAIL timeout: bench did not complete, fin0=%0b fin1=%0b", cfg[0].fin, cfg[1].fin);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
